countdown_display: RTL

- Display and status consumer for the 5-bit countdown value on the board.
- Samples the counter value each clock and shows it as two decimal digits on active-low seven-segment displays.
- Infers from the value stream whether the counter is loaded, running, paused or expired, and drives status LEDs accordingly.
- Flashes "00" when the count reaches zero.

---
 rtl/countdown_pkg.sv | 20 ++
 rtl/countdown_display_seg7.sv | 18 +
 rtl/countdown_display.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown display: state encoding and
// active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package countdown_pkg;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry n is the pattern for digit n; the first listed entry is digit 9.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/countdown_display_seg7.sv
// Combinational digit-to-segment decoder; blank (or any non-decimal digit)
// turns every segment off.
module seg7_decode
   import countdown_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (digit <= 4'd9)) begin
         seg = SEG_TABLE[digit];
      end
   end

endmodule

// File: rtl/countdown_display.sv
// Two-digit display and status LEDs for a sampled countdown value.
// Optional expiry blinking is built when COUNTDOWN_DONE_BLINK_EN is defined.
module countdown_display
   import countdown_pkg::*;
#(
   parameter int CNT_W        = 5,
   parameter int BLINK_DIV    = 25000000,
   parameter int STALL_CYCLES = 75000000
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] count,
   output logic [6:0]       hex0,
   output logic [6:0]       hex1,
   output logic             led_run,
   output logic             led_paused,
   output logic             led_done
);

   localparam int STALL_W = $clog2(STALL_CYCLES + 1);

   logic [CNT_W-1:0]   count_q;
   state_t             state;
   state_t             next_state;
   logic [STALL_W-1:0] stall_cnt;
   logic               blink_phase;
   logic [3:0]         tens;
   logic [3:0]         units;
   logic [CNT_W-1:0]   rem;
   logic [3:0]         digit_tens;
   logic [3:0]         digit_units;
   logic               blank_tens;
   logic               blank_units;
   logic [6:0]         seg_tens;
   logic [6:0]         seg_units;

   always_comb begin
      next_state = state;
      if (count == '0) begin
         next_state = S_DONE;
      end else if (count > count_q) begin
         next_state = S_LOAD;
      end else if (count < count_q) begin
         next_state = S_RUN;
      end else if ((stall_cnt == STALL_W'(STALL_CYCLES - 1)) &&
                   ((state == S_RUN) || (state == S_LOAD))) begin
         next_state = S_PAUSE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         state     <= S_LOAD;
         stall_cnt <= '0;
      end else begin
         count_q <= count;
         state   <= next_state;
         if ((count != count_q) || (count == '0)) begin
            stall_cnt <= '0;
         end else if (stall_cnt != STALL_W'(STALL_CYCLES)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

`ifdef COUNTDOWN_DONE_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_DIV + 1);

   logic [BLINK_W-1:0] blink_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (state != S_DONE) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end
`else
   assign blink_phase = 1'b0;
`endif

   // Values never exceed 31, so a compare chain replaces a real divider.
   always_comb begin
      tens = 4'd0;
      rem  = count_q;
      if (count_q >= CNT_W'(30)) begin
         tens = 4'd3;
         rem  = count_q - CNT_W'(30);
      end else if (count_q >= CNT_W'(20)) begin
         tens = 4'd2;
         rem  = count_q - CNT_W'(20);
      end else if (count_q >= CNT_W'(10)) begin
         tens = 4'd1;
         rem  = count_q - CNT_W'(10);
      end
      units = 4'(rem);
   end

   always_comb begin
      if (state == S_DONE) begin
         digit_tens  = 4'd0;
         digit_units = 4'd0;
         blank_tens  = blink_phase;
         blank_units = blink_phase;
      end else begin
         digit_tens  = tens;
         digit_units = units;
         blank_tens  = (tens == 4'd0);
         blank_units = 1'b0;
      end
   end

   seg7_decode u_seg_tens (
      .digit (digit_tens),
      .blank (blank_tens),
      .seg   (seg_tens)
   );

   seg7_decode u_seg_units (
      .digit (digit_units),
      .blank (blank_units),
      .seg   (seg_units)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex0       <= SEG_BLANK;
         hex1       <= SEG_BLANK;
         led_run    <= 1'b0;
         led_paused <= 1'b0;
         led_done   <= 1'b0;
      end else begin
         hex0       <= seg_units;
         hex1       <= seg_tens;
         led_run    <= (state == S_RUN);
         led_paused <= (state == S_PAUSE);
         led_done   <= (state == S_DONE) && !blink_phase;
      end
   end

endmodule
